ysyx_24110006_idq: RTL and testbench

Parametrised decode queue for the ysyx_24110006 core: a DEPTH-entry FIFO between IFU and EXU that buffers fetched packets (inst, imm, pc, upstream exception) and presents the head entry fully decoded. It replaces the single-register decode stage. Fetch can run ahead by DEPTH packets, flush empties the queue in one cycle, and an optional RV32E mode adds register-index legality checks.

---
 rtl/ysyx_24110006_idq_pkg.sv | 54 +++++
 rtl/ysyx_24110006_idq_if.sv | 51 +++++
 rtl/ysyx_24110006_inst_dec.sv | 73 +++++++
 rtl/ysyx_24110006_idq.sv | 125 ++++++++++++
 tb/tb_ysyx_24110006_idq.sv | 283 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ysyx_24110006_idq_pkg.sv
// Shared constants and record types for the decode queue and its instruction decoder.
// Latency: none (declarations only).
// Backpressure: not applicable.
package ysyx_24110006_idq_pkg;

    // Major opcodes recognised by the decoder
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_L     = 7'b0000011;
    localparam logic [6:0] OP_S     = 7'b0100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_B     = 7'b1100011;
    localparam logic [6:0] OP_CSR   = 7'b1110011;
    localparam logic [6:0] OP_FENCE = 7'b0001111;

    // Locally generated exception causes
    localparam logic [3:0] MCAUSE_ILLEGAL = 4'd2;
    localparam logic [3:0] MCAUSE_EBREAK  = 4'd3;
    localparam logic [3:0] MCAUSE_ECALL   = 4'd11;

    // Full-word system instruction encodings
    localparam logic [31:0] INST_EBREAK = 32'h0010_0073;
    localparam logic [31:0] INST_ECALL  = 32'h0000_0073;
    localparam logic [31:0] INST_MRET   = 32'h3020_0073;

    // One buffered fetch packet
    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] imm;
        logic [31:0] pc;
        logic        exc;
        logic [3:0]  mcause;
    } entry_t;

    // Decoder result for one instruction word
    typedef struct packed {
        logic [6:0]  op;
        logic [2:0]  func;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic        reg_wen;
        logic [1:0]  csr_t;
        logic [11:0] csr;
        logic        mret;
        logic        known;
        logic        exc;
        logic [3:0]  mcause;
    } dec_t;

endpackage

// File: rtl/ysyx_24110006_idq_if.sv
// Handshake and decoded-output bundle between IFU, the decode queue and EXU.
// Latency: none (wires only).
// Backpressure: o_ready toward IFU, i_ready from EXU.
// Ports: upstream packet + valid/ready, downstream valid/ready, flush/stall, decoded head, occupancy.
interface ysyx_24110006_idq_if #(
    parameter int DEPTH = 4
);
    logic                         i_valid;
    logic                         o_ready;
    logic [31:0]                  i_inst;
    logic [31:0]                  i_imm;
    logic [31:0]                  i_pc;
    logic                         i_exception;
    logic [3:0]                   i_mcause;
    logic                         o_valid;
    logic                         i_ready;
    logic                         i_flush;
    logic                         i_stall;
    logic [6:0]                   o_op;
    logic [2:0]                   o_func;
    logic [4:0]                   o_reg_rs1;
    logic [4:0]                   o_reg_rs2;
    logic [4:0]                   o_reg_rd;
    logic                         o_reg_wen;
    logic [31:0]                  o_imm;
    logic [31:0]                  o_pc;
    logic [1:0]                   o_csr_t;
    logic [11:0]                  o_csr;
    logic                         o_mret;
    logic                         o_exception;
    logic [3:0]                   o_mcause;
    logic [$clog2(DEPTH+1)-1:0]   o_count;

    // Driver side (fetch/execute environment)
    modport master (
        output i_valid, i_inst, i_imm, i_pc, i_exception, i_mcause,
        output i_ready, i_flush, i_stall,
        input  o_ready, o_valid, o_op, o_func, o_reg_rs1, o_reg_rs2, o_reg_rd,
        input  o_reg_wen, o_imm, o_pc, o_csr_t, o_csr, o_mret,
        input  o_exception, o_mcause, o_count
    );

    // Queue side
    modport slave (
        input  i_valid, i_inst, i_imm, i_pc, i_exception, i_mcause,
        input  i_ready, i_flush, i_stall,
        output o_ready, o_valid, o_op, o_func, o_reg_rs1, o_reg_rs2, o_reg_rd,
        output o_reg_wen, o_imm, o_pc, o_csr_t, o_csr, o_mret,
        output o_exception, o_mcause, o_count
    );
endinterface

// File: rtl/ysyx_24110006_inst_dec.sv
// Combinational RV32I/E decoder: fields, class-derived reg_wen/csr_t, local exception + cause.
// Latency: 0 cycles.
// Backpressure: none.
// Ports: inst_i (instruction word) -> dec_o (decoded record).
module ysyx_24110006_inst_dec
    import ysyx_24110006_idq_pkg::*;
#(
    parameter bit RVE          = 1'b0,
    parameter bit ZERO_ILLEGAL = 1'b1
) (
    input  logic [31:0] inst_i,
    output dec_t        dec_o
);
    logic [6:0] op;
    logic [2:0] func;
    logic [4:0] rs1, rs2, rd;
    logic c_i, c_r, c_l, c_s, c_jal, c_jalr, c_auipc, c_lui, c_b, c_csr, c_fence;
    logic reg_wen, known, csr_reg_form, use_rs1, use_rs2, bad_reg, illegal;

    assign op   = inst_i[6:0];
    assign func = inst_i[14:12];
    assign rd   = inst_i[11:7];
    assign rs1  = inst_i[19:15];
    assign rs2  = inst_i[24:20];

    assign c_i     = (op == OP_I);
    assign c_r     = (op == OP_R);
    assign c_l     = (op == OP_L);
    assign c_s     = (op == OP_S);
    assign c_jal   = (op == OP_JAL);
    assign c_jalr  = (op == OP_JALR);
    assign c_auipc = (op == OP_AUIPC);
    assign c_lui   = (op == OP_LUI);
    assign c_b     = (op == OP_B);
    assign c_csr   = (op == OP_CSR);
    assign c_fence = (op == OP_FENCE);

    assign known   = c_i | c_r | c_l | c_s | c_jal | c_jalr | c_auipc | c_lui | c_b | c_csr | c_fence;
    assign reg_wen = c_i | c_r | c_l | c_jal | c_jalr | c_auipc | c_lui;

    // csrrw/csrrs/csrrc read rs1 as a register; the immediate forms (func[2]=1) do not
    assign csr_reg_form = c_csr & (func != 3'b000) & ~func[2];
    assign use_rs1      = c_i | c_r | c_l | c_s | c_jalr | c_b | csr_reg_form;
    assign use_rs2      = c_r | c_s | c_b;

    // RV32E only has x0..x15, so bit 4 of any index that is actually used is illegal
    assign bad_reg = RVE & ((reg_wen & rd[4]) | (use_rs1 & rs1[4]) | (use_rs2 & rs2[4]));
    assign illegal = ~known | (ZERO_ILLEGAL & (inst_i == 32'h0)) | bad_reg;

    always_comb begin
        dec_o          = '0;
        dec_o.op       = op;
        dec_o.func     = func;
        dec_o.rs1      = rs1;
        dec_o.rs2      = rs2;
        dec_o.rd       = rd;
        dec_o.reg_wen  = reg_wen;
        dec_o.mret     = (inst_i == INST_MRET);
        dec_o.csr_t    = {dec_o.mret, c_csr & (func != 3'b000)};
        dec_o.csr      = inst_i[31:20];
        dec_o.known    = known;
        if (illegal) begin
            dec_o.exc    = 1'b1;
            dec_o.mcause = MCAUSE_ILLEGAL;
        end else if (inst_i == INST_EBREAK) begin
            dec_o.exc    = 1'b1;
            dec_o.mcause = MCAUSE_EBREAK;
        end else if (inst_i == INST_ECALL) begin
            dec_o.exc    = 1'b1;
            dec_o.mcause = MCAUSE_ECALL;
        end
    end
endmodule

// File: rtl/ysyx_24110006_idq.sv
// DEPTH-entry decode queue between IFU and EXU presenting the head entry fully decoded.
// Latency: 1 cycle enqueue-to-o_valid, no bypass; 1 packet/cycle sustained.
// Backpressure: o_ready = not full (from count only); flush drops same-cycle input; stall holds head.
// Ports: i_clock, i_reset (sync, active-high), bus (slave side of ysyx_24110006_idq_if).
module ysyx_24110006_idq
    import ysyx_24110006_idq_pkg::*;
#(
    parameter int DEPTH        = 4,
    parameter bit RVE          = 1'b0,
    parameter bit ZERO_ILLEGAL = 1'b1
) (
    input  logic                  i_clock,
    input  logic                  i_reset,
    ysyx_24110006_idq_if.slave    bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    entry_t          mem_q [DEPTH];
    logic [PW-1:0]   head_q, head_d, tail_q, tail_d;
    logic [CW-1:0]   count_q, count_d;
    entry_t          wr_ent, head_ent;
    dec_t            dec;
    logic            not_empty, enq, deq;

    assign not_empty = (count_q != '0);

    // Ready depends only on the registered count, so a pop never opens a slot in the same cycle
    assign bus.o_ready = (count_q != CW'(DEPTH));
    assign bus.o_valid = not_empty & ~bus.i_stall & ~bus.i_flush;
    assign bus.o_count = count_q;

    assign enq = bus.i_valid & bus.o_ready & ~bus.i_flush;
    assign deq = bus.o_valid & bus.i_ready;

    assign wr_ent = '{inst: bus.i_inst, imm: bus.i_imm, pc: bus.i_pc,
                      exc: bus.i_exception, mcause: bus.i_mcause};

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (bus.i_flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            // Power-of-two DEPTH: pointers wrap by natural overflow
            if (enq) tail_d = tail_q + 1'b1;
            if (deq) head_d = head_q + 1'b1;
            case ({enq, deq})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Payload storage is deliberately left unreset; count gates every use of it
    always_ff @(posedge i_clock) begin
        if (enq) mem_q[tail_q] <= wr_ent;
    end

    assign head_ent = mem_q[head_q];

    ysyx_24110006_inst_dec #(
        .RVE          (RVE),
        .ZERO_ILLEGAL (ZERO_ILLEGAL)
    ) u_dec (
        .inst_i (head_ent.inst),
        .dec_o  (dec)
    );

    // Empty queue shows all-zero outputs so stale RAM never raises a spurious exception
    always_comb begin
        bus.o_op        = '0;
        bus.o_func      = '0;
        bus.o_reg_rs1   = '0;
        bus.o_reg_rs2   = '0;
        bus.o_reg_rd    = '0;
        bus.o_reg_wen   = 1'b0;
        bus.o_imm       = '0;
        bus.o_pc        = '0;
        bus.o_csr_t     = '0;
        bus.o_csr       = '0;
        bus.o_mret      = 1'b0;
        bus.o_exception = 1'b0;
        bus.o_mcause    = '0;
        if (not_empty) begin
            bus.o_op        = dec.op;
            bus.o_func      = dec.func;
            bus.o_reg_rs1   = dec.rs1;
            bus.o_reg_rs2   = dec.rs2;
            bus.o_reg_rd    = dec.rd;
            bus.o_reg_wen   = dec.reg_wen;
            bus.o_imm       = head_ent.imm;
            bus.o_pc        = head_ent.pc;
            bus.o_csr_t     = dec.csr_t;
            bus.o_csr       = dec.csr;
            bus.o_mret      = dec.mret;
            // Fetch faults are older than anything found in the instruction itself
            bus.o_exception = head_ent.exc | dec.exc;
            bus.o_mcause    = head_ent.exc ? head_ent.mcause : dec.mcause;
        end
    end

`ifndef CONFIG_YOSYS
    // An unknown opcode must never reach EXU unless fetch already flagged the packet
    unsupported_opcode: assert property (@(posedge i_clock) disable iff (i_reset)
        !(deq && !dec.known && !head_ent.exc));
`endif

endmodule

// File: tb/tb_ysyx_24110006_idq.sv
module tb_ysyx_24110006_idq;
    import ysyx_24110006_idq_pkg::*;

    localparam int DEPTH = 4;
    localparam bit RVE_P = 1'b1;
    localparam bit ZI_P  = 1'b1;
    localparam logic [31:0] ADDI = 32'h0010_0093;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ysyx_24110006_idq_if #(.DEPTH(DEPTH)) bus();

    ysyx_24110006_idq #(.DEPTH(DEPTH), .RVE(RVE_P), .ZERO_ILLEGAL(ZI_P)) dut (
        .i_clock (clk),
        .i_reset (rst),
        .bus     (bus)
    );

    int total = 0;
    int bad   = 0;

    // Reference: plain queue of packets accepted and not yet consumed
    entry_t mq[$];
    entry_t cur_ent;
    logic   cur_v, cur_rdy, cur_fl, exp_v_now, exp_r_now;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // Expected decoded view of one packet, from the instruction-set rules
    function automatic logic [127:0] model_vec(input entry_t e);
        logic [6:0] op;
        logic [2:0] f;
        logic [4:0] rs1, rs2, rd;
        logic known, wen, u1, u2, csrf, illegal, mret, lexc;
        logic [3:0] cause;
        op = e.inst[6:0]; f = e.inst[14:12];
        rd = e.inst[11:7]; rs1 = e.inst[19:15]; rs2 = e.inst[24:20];
        known = 1'b1; wen = 1'b0; u1 = 1'b0; u2 = 1'b0; csrf = 1'b0;
        case (op)
            7'b0010011: begin wen = 1'b1; u1 = 1'b1; end
            7'b0110011: begin wen = 1'b1; u1 = 1'b1; u2 = 1'b1; end
            7'b0000011: begin wen = 1'b1; u1 = 1'b1; end
            7'b0100011: begin u1 = 1'b1; u2 = 1'b1; end
            7'b1101111: wen = 1'b1;
            7'b1100111: begin wen = 1'b1; u1 = 1'b1; end
            7'b0010111: wen = 1'b1;
            7'b0110111: wen = 1'b1;
            7'b1100011: begin u1 = 1'b1; u2 = 1'b1; end
            7'b1110011: begin csrf = (f != 0); u1 = (f >= 1 && f <= 3); end
            7'b0001111: ;
            default:    known = 1'b0;
        endcase
        illegal = !known || (ZI_P && e.inst == 0) ||
                  (RVE_P && ((wen && rd >= 16) || (u1 && rs1 >= 16) || (u2 && rs2 >= 16)));
        mret = (e.inst == 32'h3020_0073);
        lexc = 1'b1;
        if (illegal)                       cause = 4'd2;
        else if (e.inst == 32'h0010_0073)  cause = 4'd3;
        else if (e.inst == 32'h0000_0073)  cause = 4'd11;
        else begin lexc = 1'b0; cause = 4'd0; end
        return 128'({op, f, rs1, rs2, rd, wen, e.imm, e.pc, {mret, csrf}, e.inst[31:20], mret,
                     e.exc | lexc, e.exc ? e.mcause : cause});
    endfunction

    function automatic logic [127:0] dut_vec();
        return 128'({bus.o_op, bus.o_func, bus.o_reg_rs1, bus.o_reg_rs2, bus.o_reg_rd, bus.o_reg_wen,
                     bus.o_imm, bus.o_pc, bus.o_csr_t, bus.o_csr, bus.o_mret,
                     bus.o_exception, bus.o_mcause});
    endfunction

    // Drive one cycle of inputs and compare against the reference at the falling edge
    task automatic drive(input logic v, input logic [31:0] inst, input logic [31:0] pc,
                         input logic exc, input logic [3:0] mc,
                         input logic rdy, input logic fl, input logic st);
        cur_ent = '{inst: inst, imm: pc ^ 32'h5A5A_0000, pc: pc, exc: exc, mcause: mc};
        cur_v = v; cur_rdy = rdy; cur_fl = fl;
        bus.i_valid = v; bus.i_inst = inst; bus.i_imm = cur_ent.imm; bus.i_pc = pc;
        bus.i_exception = exc; bus.i_mcause = mc;
        bus.i_ready = rdy; bus.i_flush = fl; bus.i_stall = st;
        @(negedge clk);
        exp_v_now = (mq.size() != 0) && !st && !fl;
        exp_r_now = (mq.size() != DEPTH);
        chk("o_valid", 128'(bus.o_valid), 128'(exp_v_now));
        chk("o_ready", 128'(bus.o_ready), 128'(exp_r_now));
        chk("o_count", 128'(bus.o_count), 128'(mq.size()));
        chk("decode", dut_vec(), (mq.size() != 0) ? model_vec(mq[0]) : 128'(0));
    endtask

    task automatic tick();
        @(posedge clk);
        if (cur_fl) mq.delete();
        else begin
            if (exp_v_now && cur_rdy) void'(mq.pop_front());
            if (cur_v && exp_r_now) mq.push_back(cur_ent);
        end
        #1;
    endtask

    task automatic idle(input logic rdy);
        drive(1'b0, 32'h0, 32'h0, 1'b0, 4'h0, rdy, 1'b0, 1'b0);
    endtask

    function automatic logic [31:0] rand_inst(input logic exc);
        logic [31:0] r;
        int sel;
        r = $urandom;
        sel = $urandom_range(0, 14);
        if ($urandom_range(0, 3) != 0) begin r[24] = 1'b0; r[19] = 1'b0; r[11] = 1'b0; end
        case (sel)
            0:  r[6:0] = 7'b0010011;
            1:  r[6:0] = 7'b0110011;
            2:  r[6:0] = 7'b0000011;
            3:  r[6:0] = 7'b0100011;
            4:  r[6:0] = 7'b1101111;
            5:  r[6:0] = 7'b1100111;
            6:  r[6:0] = 7'b0010111;
            7:  r[6:0] = 7'b0110111;
            8:  r[6:0] = 7'b1100011;
            9:  r[6:0] = 7'b1110011;
            10: r[6:0] = 7'b0001111;
            11: r = 32'h0000_0073;
            12: r = 32'h0010_0073;
            13: r = 32'h3020_0073;
            default: if (!exc) r = ADDI;   // arbitrary word only when fetch flagged it
        endcase
        return r;
    endfunction

    typedef struct {
        logic [31:0] inst;
        logic        exc;
        logic [3:0]  mc;
        logic        e_exc;
        logic [3:0]  e_mc;
        logic [4:0]  e_rd;
        logic        e_wen;
        logic        e_mret;
    } vec_t;
    vec_t tv[9];

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1);
    end

    initial begin
        tv[0] = '{32'h0010_0093, 1'b0, 4'd0, 1'b0, 4'd0,  5'd1,  1'b1, 1'b0}; // addi x1,x0,1
        tv[1] = '{32'h0000_0073, 1'b0, 4'd0, 1'b1, 4'd11, 5'd0,  1'b0, 1'b0}; // ecall
        tv[2] = '{32'h0000_0073, 1'b1, 4'd1, 1'b1, 4'd1,  5'd0,  1'b0, 1'b0}; // fetch fault wins
        tv[3] = '{32'h0020_8833, 1'b0, 4'd0, 1'b1, 4'd2,  5'd16, 1'b1, 1'b0}; // add x16,x1,x2 (RVE)
        tv[4] = '{32'h0000_0000, 1'b0, 4'd0, 1'b1, 4'd2,  5'd0,  1'b0, 1'b0}; // zero word
        tv[5] = '{32'h0010_0073, 1'b0, 4'd0, 1'b1, 4'd3,  5'd0,  1'b0, 1'b0}; // ebreak
        tv[6] = '{32'h0000_007F, 1'b0, 4'd0, 1'b1, 4'd2,  5'd0,  1'b0, 1'b0}; // unknown opcode
        tv[7] = '{32'h3020_0073, 1'b0, 4'd0, 1'b0, 4'd0,  5'd0,  1'b0, 1'b1}; // mret
        tv[8] = '{32'h0000_0A37, 1'b0, 4'd0, 1'b1, 4'd2,  5'd20, 1'b1, 1'b0}; // lui x20 (RVE)

        bus.i_valid = 0; bus.i_inst = 0; bus.i_imm = 0; bus.i_pc = 0;
        bus.i_exception = 0; bus.i_mcause = 0; bus.i_ready = 0; bus.i_flush = 0; bus.i_stall = 0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state, then first packet appears one cycle after its enqueue edge
        drive(1'b1, ADDI, 32'h8000_0000, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
        chk("reset_exc", 128'(bus.o_exception), 128'(0));
        tick();
        idle(1'b0);
        chk("addi_valid", 128'(bus.o_valid), 128'(1));
        chk("addi_rd", 128'(bus.o_reg_rd), 128'(1));
        chk("addi_wen", 128'(bus.o_reg_wen), 128'(1));
        chk("addi_count", 128'(bus.o_count), 128'(1));
        tick();
        drive(1'b0, 32'h0, 32'h0, 1'b0, 4'h0, 1'b0, 1'b1, 1'b0);
        tick();

        // Table: one packet at a time, check exception merge then flush it away
        for (int i = 0; i < 9; i++) begin
            drive(1'b1, tv[i].inst, 32'h1000 + 32'(i * 4), tv[i].exc, tv[i].mc, 1'b0, 1'b0, 1'b0);
            tick();
            idle(1'b0);
            chk($sformatf("tv%0d_exc", i), 128'(bus.o_exception), 128'(tv[i].e_exc));
            chk($sformatf("tv%0d_mcause", i), 128'(bus.o_mcause), 128'(tv[i].e_mc));
            chk($sformatf("tv%0d_rd", i), 128'(bus.o_reg_rd), 128'(tv[i].e_rd));
            chk($sformatf("tv%0d_wen", i), 128'(bus.o_reg_wen), 128'(tv[i].e_wen));
            chk($sformatf("tv%0d_mret", i), 128'(bus.o_mret), 128'(tv[i].e_mret));
            tick();
            drive(1'b0, 32'h0, 32'h0, 1'b0, 4'h0, 1'b0, 1'b1, 1'b0);
            tick();
        end

        // Fill to full with EXU blocked; the fifth packet is refused
        for (int k = 0; k < 5; k++) begin
            drive(1'b1, ADDI, 32'(k * 4), 1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
            if (k == 4) chk("full_ready", 128'(bus.o_ready), 128'(0));
            tick();
        end
        idle(1'b0);
        chk("full_count", 128'(bus.o_count), 128'(4));
        tick();
        for (int k = 0; k < 4; k++) begin
            idle(1'b1);
            chk("fifo_pc", 128'(bus.o_pc), 128'(k * 4));
            tick();
        end

        // Full with push and pop together: only the pop happens
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, ADDI, 32'h20 + 32'(k * 4), 1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
            tick();
        end
        drive(1'b1, ADDI, 32'h30, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0);
        chk("fullpp_pc", 128'(bus.o_pc), 128'(32'h20));
        tick();
        drive(1'b1, ADDI, 32'h30, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
        chk("fullpp_count", 128'(bus.o_count), 128'(3));
        tick();
        for (int k = 0; k < 4; k++) begin
            idle(1'b1);
            chk("wrap_pc", 128'(bus.o_pc), 128'(32'h24 + 32'(k * 4)));
            tick();
        end

        // Flush with three entries and a same-cycle push
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, ADDI, 32'h60 + 32'(k * 4), 1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
            tick();
        end
        drive(1'b1, ADDI, 32'h99, 1'b0, 4'h0, 1'b1, 1'b1, 1'b0);
        tick();
        idle(1'b0);
        chk("flush_count", 128'(bus.o_count), 128'(0));
        chk("flush_ready", 128'(bus.o_ready), 128'(1));
        tick();

        // Stall with two entries: head held, push still accepted
        drive(1'b1, ADDI, 32'h50, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0); tick();
        drive(1'b1, ADDI, 32'h54, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0); tick();
        drive(1'b0, 32'h0, 32'h0, 1'b0, 4'h0, 1'b1, 1'b0, 1'b1);
        chk("stall_valid", 128'(bus.o_valid), 128'(0));
        tick();
        drive(1'b1, ADDI, 32'h58, 1'b0, 4'h0, 1'b1, 1'b0, 1'b1);
        chk("stall_count", 128'(bus.o_count), 128'(2));
        tick();
        idle(1'b1);
        chk("stall_head", 128'(bus.o_pc), 128'(32'h50));
        tick();
        repeat (2) begin idle(1'b1); tick(); end

        // Random traffic against the queue model
        for (int n = 0; n < 600; n++) begin
            logic e;
            e = ($urandom_range(0, 7) == 0);
            drive($urandom_range(0, 3) != 0, rand_inst(e), $urandom & 32'hFFFF_FFFC, e,
                  4'($urandom_range(0, 15)), $urandom_range(0, 2) != 0,
                  $urandom_range(0, 31) == 0, $urandom_range(0, 5) == 0);
            tick();
        end

        // Reset mid-stream
        drive(1'b1, ADDI, 32'h70, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0); tick();
        drive(1'b1, ADDI, 32'h74, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0); tick();
        bus.i_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        mq.delete();
        idle(1'b0);
        chk("rst_count", 128'(bus.o_count), 128'(0));
        chk("rst_ready", 128'(bus.o_ready), 128'(1));
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
